// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_MUL  = 2'd2,
        SRC_DIV  = 2'd3
    } src_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

endpackage

// File: rtl/wb_rr_pick.sv
// Two-requester round-robin picker; index 0 is MUL, index 1 is DIV.
module wb_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // On contention, favour the requester that did not win last time.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Regfile write-port arbiter for WB, multiplier and divider results.
// Optional perf counters enabled by defining WB_ARB_PERF_EN.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_valid,
    input  logic            pipe_wen,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_data,
    input  logic            mul_valid,
    input  logic [4:0]      mul_rd,
    input  logic [XLEN-1:0] mul_data,
    output logic            mul_ready,
    input  logic            div_valid,
    input  logic [4:0]      div_rd,
    input  logic [XLEN-1:0] div_data,
    output logic            div_ready,
    output logic            stall_pipe,
    output logic            rf_wen,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_data
`ifdef WB_ARB_PERF_EN
    ,
    output logic [63:0]     perf_conflict,
    output logic [63:0]     perf_force
`endif
);

    localparam int CW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rr_last_q, rr_last_d;
    logic              rf_wen_q, rf_wen_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_data_q, rf_data_d;

    logic              pipe_req;
    logic              unit_any;
    logic              unit_grant;
    logic [1:0]        unit_gnt;
    src_t              src;

    assign stall_pipe = (state_q == FORCE);
    assign pipe_req   = pipe_valid & pipe_wen & ~stall_pipe;
    assign unit_any   = mul_valid | div_valid;

    wb_rr_pick u_pick (
        .req  ({div_valid, mul_valid}),
        .last (rr_last_q),
        .gnt  (unit_gnt)
    );

    always_comb begin
        src = SRC_NONE;
        if (!rst) begin
            if (pipe_req) begin
                src = SRC_PIPE;
            end else if (unit_gnt[0]) begin
                src = SRC_MUL;
            end else if (unit_gnt[1]) begin
                src = SRC_DIV;
            end
        end
    end

    assign mul_ready  = (src == SRC_MUL);
    assign div_ready  = (src == SRC_DIV);
    assign unit_grant = mul_ready | div_ready;

    always_comb begin
        state_d   = NORMAL;
        cnt_d     = cnt_q;
        rr_last_d = rr_last_q;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;

        // Starvation is only tracked while WB may still win the port.
        if (state_q == NORMAL) begin
            if (unit_grant || !unit_any) begin
                cnt_d = '0;
            end else if (32'(cnt_q) + 32'd1 == STARVE_LIMIT) begin
                state_d = FORCE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        unique case (src)
            SRC_PIPE: begin
                rf_rd_d   = pipe_rd;
                rf_data_d = pipe_data;
            end
            SRC_MUL: begin
                rf_rd_d   = mul_rd;
                rf_data_d = mul_data;
                rr_last_d = 1'b0;
            end
            SRC_DIV: begin
                rf_rd_d   = div_rd;
                rf_data_d = div_data;
                rr_last_d = 1'b1;
            end
            default: ;
        endcase

        rf_wen_d = (src != SRC_NONE) && (rf_rd_d != 5'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NORMAL;
            cnt_q     <= '0;
            rr_last_q <= 1'b1;
            rf_wen_q  <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_last_q <= rr_last_d;
            rf_wen_q  <= rf_wen_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    assign rf_wen  = rf_wen_q;
    assign rf_rd   = rf_rd_q;
    assign rf_data = rf_data_q;

`ifdef WB_ARB_PERF_EN
    logic [63:0] perf_conflict_q, perf_conflict_d;
    logic [63:0] perf_force_q, perf_force_d;

    always_comb begin
        perf_conflict_d = perf_conflict_q;
        perf_force_d    = perf_force_q;
        if (unit_any && src == SRC_PIPE) begin
            perf_conflict_d = perf_conflict_q + 64'd1;
        end
        if (state_q == FORCE) begin
            perf_force_d = perf_force_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_conflict_q <= '0;
            perf_force_q    <= '0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_force_q    <= perf_force_d;
        end
    end

    assign perf_conflict = perf_conflict_q;
    assign perf_force    = perf_force_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter against a cycle-level reference model.
module tb_wb_port_arbiter;

    localparam int XLEN  = 64;
    localparam int LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            pipe_valid, pipe_wen;
    logic [4:0]      pipe_rd;
    logic [XLEN-1:0] pipe_data;
    logic            mul_valid, div_valid;
    logic [4:0]      mul_rd, div_rd;
    logic [XLEN-1:0] mul_data, div_data;
    logic            mul_ready, div_ready, stall_pipe;
    logic            rf_wen;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_data;
`ifdef WB_ARB_PERF_EN
    logic [63:0]     perf_conflict, perf_force;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_wen   (pipe_wen),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mul_valid  (mul_valid),
        .mul_rd     (mul_rd),
        .mul_data   (mul_data),
        .mul_ready  (mul_ready),
        .div_valid  (div_valid),
        .div_rd     (div_rd),
        .div_data   (div_data),
        .div_ready  (div_ready),
        .stall_pipe (stall_pipe),
        .rf_wen     (rf_wen),
        .rf_rd      (rf_rd),
        .rf_data    (rf_data)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflict (perf_conflict),
        .perf_force    (perf_force)
`endif
    );

    typedef struct packed {
        logic stall;
        logic mr;
        logic dr;
    } hs_t;

    typedef struct packed {
        logic            wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } rf_t;

    hs_t hs_q[$];
    rf_t rf_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mul_acc = 1'b0;
    bit  div_acc = 1'b0;
    bit  rst_prev = 1'b1;

    task automatic check(input string nm, input logic [XLEN-1:0] act,
                         input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] gen_rd();
        if ($urandom_range(0, 3) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    // Reference model: who owns the port this cycle, and what lands next cycle.
    initial begin
        bit              m_force;
        int              m_wait;
        bit              m_pref_mul;
        logic [4:0]      m_rd;
        logic [XLEN-1:0] m_data;
        int              win;
        hs_t             h;
        rf_t             r;
        m_force = 0; m_wait = 0; m_pref_mul = 1; m_rd = '0; m_data = '0;
        forever begin
            @(posedge clk);
            #3;
            h.stall = m_force;
            if (rst) begin
                h.mr = 1'b0;
                h.dr = 1'b0;
                m_force = 0; m_wait = 0; m_pref_mul = 1;
                m_rd = '0; m_data = '0;
                mul_acc = 0; div_acc = 0;
                r = '0;
            end else begin
                win = 0;
                if (!m_force && pipe_valid && pipe_wen) win = 1;
                else if (mul_valid && div_valid) win = m_pref_mul ? 2 : 3;
                else if (mul_valid) win = 2;
                else if (div_valid) win = 3;
                h.mr = (win == 2);
                h.dr = (win == 3);
                mul_acc = h.mr;
                div_acc = h.dr;
                if (win == 2) m_pref_mul = 0;
                if (win == 3) m_pref_mul = 1;
                if (m_force) begin
                    m_force = 0;
                end else if (win >= 2 || !(mul_valid || div_valid)) begin
                    m_wait = 0;
                end else begin
                    m_wait++;
                    if (m_wait == LIMIT) begin
                        m_force = 1;
                        m_wait = 0;
                    end
                end
                case (win)
                    1: begin m_rd = pipe_rd; m_data = pipe_data; end
                    2: begin m_rd = mul_rd;  m_data = mul_data;  end
                    3: begin m_rd = div_rd;  m_data = div_data;  end
                    default: ;
                endcase
                r.wen  = (win != 0) && (m_rd != 5'd0);
                r.rd   = m_rd;
                r.data = m_data;
            end
            hs_q.push_back(h);
            rf_q.push_back(r);
        end
    end

    // Monitor: handshake outputs now, registered write port one cycle later.
    initial begin
        hs_t h;
        rf_t r;
        forever begin
            @(posedge clk);
            #4;
            if (hs_q.size() > 0) begin
                h = hs_q.pop_front();
                check("stall_pipe", XLEN'(stall_pipe), XLEN'(h.stall));
                check("mul_ready", XLEN'(mul_ready), XLEN'(h.mr));
                check("div_ready", XLEN'(div_ready), XLEN'(h.dr));
            end
            if (rf_q.size() >= 2) begin
                r = rf_q.pop_front();
                check("rf_wen", XLEN'(rf_wen), XLEN'(r.wen));
                check("rf_rd", XLEN'(rf_rd), XLEN'(r.rd));
                check("rf_data", rf_data, r.data);
            end
        end
    end

    // pm: 0 idle, 1 write every cycle, 2 random, 3 valid without wen
    // um: 0 none, 1 mul, 2 div, 3 both, 4 random
    task automatic drive(input bit r, input int pm, input int um);
        @(posedge clk);
        #1;
        rst = r;
        case (pm)
            1:       begin pipe_valid = 1'b1; pipe_wen = 1'b1; end
            2:       begin
                pipe_valid = 1'($urandom_range(0, 1));
                pipe_wen   = 1'($urandom_range(0, 1));
            end
            3:       begin pipe_valid = 1'b1; pipe_wen = 1'b0; end
            default: begin pipe_valid = 1'b0; pipe_wen = 1'b0; end
        endcase
        pipe_rd   = gen_rd();
        pipe_data = {$urandom, $urandom};
        if (!mul_valid || mul_acc || rst_prev) begin
            mul_valid = (um == 1 || um == 3) ? 1'b1 :
                        (um == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            mul_rd    = gen_rd();
            mul_data  = {$urandom, $urandom};
        end
        if (!div_valid || div_acc || rst_prev) begin
            div_valid = (um == 2 || um == 3) ? 1'b1 :
                        (um == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            div_rd    = gen_rd();
            div_data  = {$urandom, $urandom};
        end
        rst_prev = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pipe_valid = 0; pipe_wen = 0; pipe_rd = '0; pipe_data = '0;
        mul_valid = 0; mul_rd = '0; mul_data = '0;
        div_valid = 0; div_rd = '0; div_data = '0;

        repeat (3) drive(1, 0, 0);
        drive(0, 0, 1);
        repeat (3) drive(0, 0, 0);

        drive(1, 0, 0);
        repeat (12) drive(0, 1, 2);
        repeat (2) drive(0, 0, 0);

        drive(1, 0, 0);
        repeat (8) drive(0, 0, 3);
        repeat (2) drive(0, 0, 0);

        repeat (4) drive(0, 3, 2);
        repeat (2) drive(0, 0, 0);

        drive(1, 0, 0);
        repeat (4) drive(0, 1, 1);
        drive(1, 1, 1);
        repeat (3) drive(0, 0, 3);

        repeat (2000) drive($urandom_range(0, 99) == 0, 2, 4);
        for (int k = 0; k < 300; k++) drive(0, (k % 40 < 20) ? 1 : 2, 4);
        repeat (3) drive(0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
